// File: rtl/iter_counter.sv
// iter_counter: bounded iteration counter with start/stop/hold control.
// A run counts 0..lim_q, then raises a one-cycle done pulse and returns to idle.
module iter_counter #(
  parameter int unsigned WIDTH      = 6,
  parameter bit          RESTART_OK = 1'b1
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  // busy is the state bit itself, so the encoding is fixed to match it
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_lim_q;
  logic             r_done;
  logic             w_at_lim;

  assign w_at_lim = (r_count == r_lim_q);

  // Run control: priority is clr > stop > restart > hold > count/complete
  always_ff @(posedge clock) begin
    if (clr) begin
      r_state <= IDLE;
      r_count <= '0;
      r_lim_q <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state <= RUN;
            r_count <= '0;
            r_lim_q <= limit;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (start && RESTART_OK) begin
            r_count <= '0;
            r_lim_q <= limit;
          end else if (!hold) begin
            if (w_at_lim) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign done  = r_done;
  assign last  = busy && !hold && w_at_lim;

endmodule
